outport_scheduler: RTL

- One instance per output port of the hexa router.
- Shares one output link among the 5 inports (x+, x-, y+, y-, pe) using round-robin arbitration with wormhole locking.
- Issues one flit-transfer acknowledge per cycle and drives the one-hot crossbar select for its output column.
- Gates every transfer on downstream buffer credits tracked in a local counter.

---
 rtl/hexa_pkg.sv | 27 ++
 rtl/outport_scheduler_if.sv | 30 +++
 rtl/rr_priority_picker.sv | 31 +++
 rtl/outport_scheduler.sv | 122 ++++++++++++
 4 files changed

// File: rtl/hexa_pkg.sv
// Shared constants, types and width helpers for the hexa router output schedulers.
package hexa_pkg;

  localparam int PORTS_DEF        = 5;
  localparam int BUFFER_DEPTH_DEF = 4;

  localparam int XPLUS  = 0;
  localparam int XMINUS = 1;
  localparam int YPLUS  = 2;
  localparam int YMINUS = 3;
  localparam int PE     = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_t;

  // Counter must hold every value 0..depth inclusive.
  function automatic int cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/outport_scheduler_if.sv
// Request/acknowledge bundle between the inports and one output-port scheduler.
interface outport_scheduler_if
  import hexa_pkg::*;
#(
  parameter int PORTS        = PORTS_DEF,
  parameter int BUFFER_DEPTH = BUFFER_DEPTH_DEF
);

  localparam int CW = cw(BUFFER_DEPTH);

  logic [0:PORTS-1] port_rqs;
  logic [0:PORTS-1] tail_in;
  logic             credit_in;
  logic [0:PORTS-1] arb_ack;
  logic [0:PORTS-1] xbar_cfg_vector;
  logic             busy;
  logic [CW-1:0]    credit_count;
  logic             credit_overflow;

  modport master (
    output port_rqs, tail_in, credit_in,
    input  arb_ack, xbar_cfg_vector, busy, credit_count, credit_overflow
  );

  modport slave (
    input  port_rqs, tail_in, credit_in,
    output arb_ack, xbar_cfg_vector, busy, credit_count, credit_overflow
  );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_priority_picker
  import hexa_pkg::*;
#(
  parameter int  PORTS = PORTS_DEF,
  localparam int PW    = idx_width(PORTS)
) (
  input  logic [0:PORTS-1] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    winner,
  output logic             valid
);

  logic [PW-1:0] cand;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    // Offset 1 first; offset PORTS wraps back to ptr itself as lowest priority.
    for (int i = 1; i <= PORTS; i++) begin
      cand = PW'((int'(ptr) + i) % PORTS);
      if (!valid && req[cand]) begin
        winner = cand;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/outport_scheduler.sv
// Output-port scheduler: round-robin wormhole arbitration gated by downstream credits.
module outport_scheduler
  import hexa_pkg::*;
#(
  parameter int PORTS        = PORTS_DEF,
  parameter int BUFFER_DEPTH = BUFFER_DEPTH_DEF,
  parameter int CW           = cw(BUFFER_DEPTH)
) (
  input logic                clk,
  input logic                rst,
  outport_scheduler_if.slave bus
);

  localparam int PW = idx_width(PORTS);

  sched_state_t     state_q, state_d;
  logic [PW-1:0]    owner_q;
  logic [PW-1:0]    rr_ptr_q;
  logic [PW-1:0]    winner;
  logic             winner_valid;
  logic [CW-1:0]    credit_q;
  logic [0:PORTS-1] xbar_q;
  logic [0:PORTS-1] ack_vec;
  logic             busy_q;
  logic             overflow_q;
  logic             ack_now;
  logic             grant_now;
  logic             release_now;

  function automatic logic [0:PORTS-1] onehot(input logic [PW-1:0] idx);
    logic [0:PORTS-1] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  rr_priority_picker #(.PORTS(PORTS)) u_picker (
    .req    (bus.port_rqs),
    .ptr    (rr_ptr_q),
    .winner (winner),
    .valid  (winner_valid)
  );

  always_comb begin
    state_d     = state_q;
    ack_vec     = '0;
    ack_now     = 1'b0;
    grant_now   = 1'b0;
    release_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (winner_valid) begin
          grant_now = 1'b1;
          state_d   = LOCKED;
        end
      end
      LOCKED: begin
        // Only the owner can ever be acked; others wait for its tail.
        ack_now          = bus.port_rqs[owner_q] && (credit_q != '0);
        ack_vec[owner_q] = ack_now;
        if (ack_now && bus.tail_in[owner_q]) begin
          release_now = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q  <= '0;
      rr_ptr_q <= PW'(PORTS - 1);
      xbar_q   <= '0;
      busy_q   <= 1'b0;
    end else if (grant_now) begin
      owner_q <= winner;
      xbar_q  <= onehot(winner);
      busy_q  <= 1'b1;
    end else if (release_now) begin
      rr_ptr_q <= owner_q;
      xbar_q   <= '0;
      busy_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_q   <= CW'(BUFFER_DEPTH);
      overflow_q <= 1'b0;
    end else begin
      case ({ack_now, bus.credit_in})
        2'b10: credit_q <= credit_q - CW'(1);
        2'b01: begin
          // A return beyond the buffer depth means upstream miscounted; saturate and flag.
          if (credit_q == CW'(BUFFER_DEPTH)) begin
            overflow_q <= 1'b1;
          end else begin
            credit_q <= credit_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.arb_ack         = ack_vec;
  assign bus.xbar_cfg_vector = xbar_q;
  assign bus.busy            = busy_q;
  assign bus.credit_count    = credit_q;
  assign bus.credit_overflow = overflow_q;

endmodule
